decode_stage_buffered: RTL and testbench
========================================

Name: decode_stage_buffered

Overview:
Parametrised, elastic RV32I decode pipeline stage with valid/ready handshakes on both sides.
- Decodes the fetched instruction and reads the register file combinationally.
- Captures the result into a DEPTH-entry output FIFO.
- Adds back-pressure, flush and load-use hazard stalling.
- Sits between fetch and execute; execute pops decoded bundles at its own rate.

Parameters:
XLEN, 32, data/PC/immediate width (32 only for RV32I)
ILEN, 32, instruction width
DEPTH, 2, output buffer entries; power of two, >=1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  ILEN  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  discard all buffered and offered work
rs1_addr  out  5  regfile read addr A, combinational from in_instr
rs2_addr  out  5  regfile read addr B, combinational from in_instr
rs1_data  in  XLEN  regfile read data A, same cycle
rs2_data  in  XLEN  regfile read data B, same cycle
ex_valid  in  1  execute holds a valid instruction
ex_is_load  in  1  that instruction is a load
ex_rd  in  5  its destination register
out_valid  out  1  FIFO head valid
out_ready  in  1  execute consumes head
out_pc, out_imm, out_reg_a, out_reg_b  out  XLEN each  head bundle fields
out_opcode  out  7;  out_funct3  out  3;  out_funct7  out  7
out_rd, out_rs1, out_rs2  out  5 each
out_illegal  out  1  head is illegal (optional feature)

Behaviour:
- Decode rules, combinational on in_instr:
  - R-type: rd, rs1, rs2, funct3, funct7.
  - OP-IMM, LOAD, JALR: rd, rs1, funct3, imm = sext(instr[31:20]).
  - STORE: rs1, rs2, funct3, imm = sext({[31:25],[11:7]}).
  - BRANCH: rs1, rs2, funct3, imm = sext({[31],[7],[30:25],[11:8],0}).
  - LUI, AUIPC: rd, imm = {[31:12],12'b0}.
  - JAL: rd, imm = sext({[31],[19:12],[20],[30:21],0}).
  - Fields a format does not use are 0.
  - Unknown opcode: all fields 0 except pc and opcode.
- rs1_addr/rs2_addr are driven from decoded rs1/rs2 (0 when unused). reg_a/reg_b are sampled from rs1_data/rs2_data in the accept cycle.
- hazard = ex_valid & ex_is_load & (ex_rd != 0) & ((ex_rd == rs1 & rs1 used) | (ex_rd == rs2 & rs2 used)).
- in_ready = (count < DEPTH) & ~hazard & ~flush. No pass-through when full; a pop in a full cycle frees a slot for the next cycle only.
- push = in_valid & in_ready; pop = out_valid & out_ready. Latency: the instruction accepted at edge N appears at the head after edge N, provided the FIFO was empty.
- The FIFO is built from wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Occupancy states: EMPTY (count 0, out_valid 0), PARTIAL, FULL (in_ready 0).
- Output fields show the head entry. They hold stable while out_valid & ~out_ready.
- flush: at the next edge, pointers and count go to 0 and no push occurs. flush has priority over push and pop.
- Reset (async, rst_n low): pointers and count go to 0, out_valid 0, all out_* 0, out_illegal 0. in_ready is 1 once rst_n is high (if no hazard or flush).
- Reset asserted mid-operation drops all buffered entries immediately.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined:
  - out_illegal=1 for an unknown opcode, and for OP with funct7 other than 0x00/0x20 or 0x20 used with funct3 other than ADD/SRL.
  - The entry is still buffered and forwarded so execute can trap.
- Undefined: out_illegal is tied 0 and unknown opcodes pass as zero-field bundles.

Test Plan:
1. Assert rst_n=0 with random inputs, then release -> out_valid=0, all out_* = 0, in_ready=1 on the next cycle.
2. Offer ADDI x5,x1,-1 (0xFFF08293) at pc 0x100 with rs1_data=0x10 and out_ready=1 -> next cycle out_valid=1, out_rd=5, out_rs1=1, out_imm=0xFFFFFFFF, out_reg_a=0x10, out_pc=0x100.
3. Offer BEQ x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, out_funct3=0, out_rd=0.
4. DEPTH=2, out_ready=0, offer 3 back-to-back instructions -> in_ready drops after 2 are accepted. Raise out_ready -> entries pop in order and the third is accepted on the cycle after the first pop.
5. ex_valid=1, ex_is_load=1, ex_rd=5 while offering ADD x6,x5,x2 (0x00228333) -> in_ready=0. Drop ex_valid -> accepted the same cycle.
6. With 2 entries buffered and in_valid=1, pulse flush for one cycle -> out_valid=0 next cycle, count 0, offered instruction not captured. With DECODE_ILLEGAL_TRAP_EN, then offer 0x00000000 -> out_illegal=1.

Source files
------------

// File: rtl/decode_stage_buffered.sv
// rtl/decode_stage_buffered.sv - RV32I decode stage with DEPTH-entry elastic output buffer
// Optional macro DECODE_ILLEGAL_TRAP_EN flags unknown opcodes and bad OP funct7/funct3 combinations.
module decode_stage_buffered #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_reg_a,
    output logic [XLEN-1:0] out_reg_b,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] reg_a;
        logic [XLEN-1:0] reg_b;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
    } entry_t;

    entry_t          dec;
    logic            use_rs1;
    logic            use_rs2;
    logic            hazard;
    logic            push;
    logic            pop;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          mem [0:(1<<PW)-1];
    entry_t          head;

    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.pc     = in_pc;
        dec.opcode = in_instr[6:0];
        dec.reg_a  = rs1_data;
        dec.reg_b  = rs2_data;
        case (in_instr[6:0])
            OPC_OP: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                dec.funct7 = in_instr[31:25];
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
                // Only base-ISA funct7 values; 0x20 is meaningful for SUB and SRA alone.
                dec.illegal = ((in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20)) ||
                              ((in_instr[31:25] == 7'h20) && (in_instr[14:12] != 3'b000) &&
                               (in_instr[14:12] != 3'b101));
`endif
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.funct3 = in_instr[14:12];
                dec.imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                use_rs1    = 1'b1;
            end
            OPC_STORE: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                dec.imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_BRANCH: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                dec.imm    = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.rd         = in_instr[11:7];
                dec.imm[31:12] = in_instr[31:12];
            end
            OPC_JAL: begin
                dec.rd  = in_instr[11:7];
                dec.imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                // Unknown opcode: only pc and opcode survive so execute sees a clean bundle.
                dec.reg_a = '0;
                dec.reg_b = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
    end

    assign rs1_addr = dec.rs1;
    assign rs2_addr = dec.rs2;

    assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && (ex_rd == dec.rs1)) || (use_rs2 && (ex_rd == dec.rs2)));

    assign out_valid = (count != '0);
    assign in_ready  = (count < CW'(DEPTH)) && !hazard && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_reg_a   = head.reg_a;
    assign out_reg_b   = head.reg_b;
    assign out_opcode  = head.opcode;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage_buffered.sv
// tb/tb_decode_stage_buffered.sv - self-checking bench for decode_stage_buffered
`timescale 1ns/1ps
module tb_decode_stage_buffered;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, flush, ex_valid, ex_is_load, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd, out_rd, out_rs1, out_rs2;
    logic [31:0] out_pc, out_imm, out_reg_a, out_reg_b;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;

    decode_stage_buffered #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_reg_a(out_reg_a), .out_reg_b(out_reg_b),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [31:0] pc, imm, ra, rb;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic        ill;
    } bundle_t;

    function automatic logic [191:0] dut_head();
        return 192'({out_pc, out_imm, out_reg_a, out_reg_b, out_opcode, out_funct3, out_funct7,
                     out_rd, out_rs1, out_rs2, out_illegal});
    endfunction

    function automatic int sext(input int v, input int n);
        return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
    endfunction

    // Instruction format letter from the opcode; 'X' means not an RV32I base opcode handled here.
    function automatic byte fmt_of(input logic [6:0] op);
        case (op)
            7'h33:                return "R";
            7'h13, 7'h03, 7'h67:  return "I";
            7'h23:                return "S";
            7'h63:                return "B";
            7'h37, 7'h17:         return "U";
            7'h6F:                return "J";
            default:              return "X";
        endcase
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] i, input logic [31:0] pc,
                                             input logic [31:0] ra, input logic [31:0] rb);
        bundle_t b = '0;
        byte f = fmt_of(i[6:0]);
        bit bad;
        b.pc = pc;
        b.op = i[6:0];
        if (f != "X") begin b.ra = ra; b.rb = rb; end
        if (f == "R" || f == "I" || f == "U" || f == "J") b.rd = i[11:7];
        if (f == "R" || f == "I" || f == "S" || f == "B") begin b.rs1 = i[19:15]; b.f3 = i[14:12]; end
        if (f == "R" || f == "S" || f == "B") b.rs2 = i[24:20];
        if (f == "R") b.f7 = i[31:25];
        case (f)
            "I": b.imm = sext(int'(i[31:20]), 12);
            "S": b.imm = sext(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
            "B": b.imm = sext(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                              int'(i[11:8]) * 2, 13);
            "U": b.imm = i & 32'hFFFFF000;
            "J": b.imm = sext(int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
                              int'(i[30:21]) * 2, 21);
            default: b.imm = 0;
        endcase
        bad = (f == "X") ||
              (f == "R" && !(i[31:25] == 7'h00 || (i[31:25] == 7'h20 && (i[14:12] == 0 || i[14:12] == 5))));
        b.ill = TRAP && bad;
        return b;
    endfunction

    function automatic bit model_hazard(input logic [31:0] i, input logic ev, input logic el,
                                        input logic [4:0] er);
        byte f = fmt_of(i[6:0]);
        bit r1 = (f == "R" || f == "I" || f == "S" || f == "B");
        bit r2 = (f == "R" || f == "S" || f == "B");
        return ev && el && er != 0 && ((r1 && er == i[19:15]) || (r2 && er == i[24:20]));
    endfunction

    typedef struct {
        logic [31:0] instr, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          ill, known;
    } vec_t;

    vec_t vecs[14];

    task automatic idle_inputs();
        in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; rs1_data = 0; rs2_data = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_pc = pc;
    endtask

    bundle_t q[$];
    bundle_t eb;

    initial begin
        vecs[0]  = '{32'hFFF08293, 32'hFFFFFFFF, 5, 1, 0, 0, 7'h00, 0, 1};
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 0, 0, 0, 0, 7'h00, 0, 1};
        vecs[2]  = '{32'h00228333, 32'h00000000, 6, 5, 2, 0, 7'h00, 0, 1};
        vecs[3]  = '{32'h0020A423, 32'h00000008, 0, 1, 2, 2, 7'h00, 0, 1};
        vecs[4]  = '{32'h123451B7, 32'h12345000, 3, 0, 0, 0, 7'h00, 0, 1};
        vecs[5]  = '{32'h001000EF, 32'h00000800, 1, 0, 0, 0, 7'h00, 0, 1};
        vecs[6]  = '{32'hFFFFF517, 32'hFFFFF000, 10, 0, 0, 0, 7'h00, 0, 1};
        vecs[7]  = '{32'hFF012203, 32'hFFFFFFF0, 4, 2, 0, 2, 7'h00, 0, 1};
        vecs[8]  = '{32'h409403B3, 32'h00000000, 7, 8, 9, 0, 7'h20, 0, 1};
        vecs[9]  = '{32'h023100B3, 32'h00000000, 1, 2, 3, 0, 7'h01, 1, 1};
        vecs[10] = '{32'h00000000, 32'h00000000, 0, 0, 0, 0, 7'h00, 1, 0};
        vecs[11] = '{32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 0, 7'h00, 1, 0};
        vecs[12] = '{32'h403160B3, 32'h00000000, 1, 2, 3, 6, 7'h20, 1, 1};
        vecs[13] = '{32'h004280E7, 32'h00000004, 1, 5, 0, 0, 7'h00, 0, 1};

        // Reset with random inputs applied
        rst_n = 0;
        in_valid = 1; in_instr = $urandom; in_pc = $urandom; flush = 0;
        rs1_data = $urandom; rs2_data = $urandom; ex_valid = 0; ex_is_load = 0; ex_rd = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_head_zero", dut_head(), 192'd0);
        rst_n = 1;
        idle_inputs();
        @(negedge clk); #1;
        check("reset_in_ready", in_ready, 1'b1);

        // Table-driven decode vectors, one instruction at a time through an empty FIFO
        foreach (vecs[k]) begin
            logic [31:0] pc = 32'h100 + 32'(k) * 4;
            logic [31:0] ra = $urandom;
            logic [31:0] rb = $urandom;
            @(negedge clk);
            out_ready = 0;
            offer(vecs[k].instr, pc);
            rs1_data = ra; rs2_data = rb;
            #1;
            check($sformatf("vec%0d_rf_addr", k), {rs1_addr, rs2_addr}, {vecs[k].rs1, vecs[k].rs2});
            @(negedge clk);
            in_valid = 0; rs1_data = 0; rs2_data = 0;
            #1;
            check($sformatf("vec%0d_head", k), dut_head(),
                  192'({pc, vecs[k].imm, vecs[k].known ? ra : 32'd0, vecs[k].known ? rb : 32'd0,
                        vecs[k].instr[6:0], vecs[k].f3, vecs[k].f7, vecs[k].rd, vecs[k].rs1,
                        vecs[k].rs2, TRAP & vecs[k].ill}));
            out_ready = 1;
        end
        @(negedge clk);
        out_ready = 0; #1;
        check("table_drained", out_valid, 1'b0);

        // Back-pressure: two fill DEPTH=2, third waits for the first pop
        do_reset();
        offer(32'h00100093, 32'h200); #1;
        check("bp_ready_0", in_ready, 1'b1);
        @(negedge clk); offer(32'h00200113, 32'h204); #1;
        check("bp_ready_1", in_ready, 1'b1);
        @(negedge clk); offer(32'h00300193, 32'h208); #1;
        check("bp_full_ready", in_ready, 1'b0);
        check("bp_head_first", out_rd, 5'd1);
        out_ready = 1;
        #1;
        check("bp_no_passthrough", in_ready, 1'b0);
        @(negedge clk); #1;
        check("bp_head_second", out_rd, 5'd2);
        check("bp_third_ready", in_ready, 1'b1);
        @(negedge clk); in_valid = 0; #1;
        check("bp_head_third", {out_rd, out_pc}, {5'd3, 32'h208});
        @(negedge clk); #1;
        check("bp_drained", out_valid, 1'b0);
        out_ready = 0;

        // Load-use hazard on rs1 and rs2
        do_reset();
        offer(32'h00228333, 32'h300);
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; #1;
        check("hz_rs1", in_ready, 1'b0);
        ex_rd = 2; #1;
        check("hz_rs2", in_ready, 1'b0);
        ex_is_load = 0; #1;
        check("hz_not_load", in_ready, 1'b1);
        ex_is_load = 1; ex_rd = 7; #1;
        check("hz_other_rd", in_ready, 1'b1);
        ex_rd = 5; @(negedge clk); #1;
        check("hz_held", out_valid, 1'b0);
        ex_valid = 0; #1;
        check("hz_release", in_ready, 1'b1);
        @(negedge clk); in_valid = 0; #1;
        check("hz_accepted", {out_valid, out_rd}, {1'b1, 5'd6});

        // Flush with 2 entries buffered and an instruction on offer
        do_reset();
        offer(32'h00100093, 32'h400);
        @(negedge clk); offer(32'h00200113, 32'h404);
        @(negedge clk); offer(32'h00300193, 32'h408); flush = 1; out_ready = 1; #1;
        check("fl_ready_low", in_ready, 1'b0);
        @(negedge clk); flush = 0; in_valid = 0; out_ready = 0; #1;
        check("fl_empty", {out_valid, dut_head()}, 193'd0);
        check("fl_ready_after", in_ready, 1'b1);
        offer(32'h00000000, 32'h500);
        @(negedge clk); in_valid = 0; #1;
        check("fl_zero_instr", {out_valid, out_illegal, out_pc}, {1'b1, TRAP, 32'h500});

        // Asynchronous reset mid-operation
        offer(32'h00500293, 32'h504);
        @(negedge clk); in_valid = 0; #2;
        rst_n = 0; #1;
        check("async_reset_drop", {out_valid, dut_head()}, 193'd0);
        @(negedge clk); rst_n = 1;

        // Randomised run against the queue model
        q.delete();
        for (int c = 0; c < 1500; c++) begin
            logic [6:0] ops[12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                                    7'h6F, 7'h00, 7'h7F, 7'h73};
            logic [31:0] ins;
            bit hz, er, pu, po;
            @(negedge clk);
            ins = {$urandom} & 32'hFFFFFF80 | 32'(ops[$urandom_range(0, 11)]);
            if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = ins; in_pc = $urandom;
            rs1_data = $urandom; rs2_data = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            ex_valid = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0: ex_rd = ins[19:15];
                1: ex_rd = ins[24:20];
                default: ex_rd = 5'($urandom);
            endcase
            #1;
            eb = model_decode(ins, in_pc, rs1_data, rs2_data);
            hz = model_hazard(ins, ex_valid, ex_is_load, ex_rd);
            er = (q.size() < DEPTH) && !hz && !flush;
            check("rnd_in_ready", in_ready, er);
            check("rnd_rf_addr", {rs1_addr, rs2_addr}, {eb.rs1, eb.rs2});
            check("rnd_out_valid", out_valid, q.size() != 0);
            check("rnd_head", dut_head(), (q.size() != 0) ? 192'(q[0]) : 192'd0);
            if (flush) q.delete();
            else begin
                po = (q.size() != 0) && out_ready;
                pu = in_valid && er;
                if (po) void'(q.pop_front());
                if (pu) q.push_back(eb);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks so far %0d", checks);
        $fatal(1);
    end

endmodule
